// File: rtl/event_detector_pkg.sv
// Shared types for the elevator input event detector.
package event_detector_pkg;

  typedef enum logic [1:0] {
    EDGE_ANY  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/event_detector_bit_debouncer.sv
// Single-channel debounce filter: accepts a new level after DEBOUNCE
// consecutive differing samples and strobes rise/fall on that cycle.
module bit_debouncer
  import event_detector_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;
  logic          expire;

  // Strobes are combinational so the top can register the event on the
  // same edge that updates stable.
  assign expire = (in != stable) && (cnt == LAST);
  assign rise   = expire & in;
  assign fall   = expire & ~in;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (in == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= in;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/event_detector.sv
// Multi-channel debounced edge detector with sticky pending/overrun flags
// and a lowest-index priority encoder for the request scheduler.
module event_detector
  import event_detector_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  edge_mode_t       mode,
  input  logic [WIDTH-1:0] ack,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun,
  output logic             any_pending,
  output logic [IDX_W-1:0] first_idx
);

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] qualified;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  always_comb begin
    qualified = '0;
    case (mode)
      EDGE_ANY:  qualified = rise | fall;
      EDGE_RISE: qualified = rise;
      EDGE_FALL: qualified = fall;
      default:   qualified = '0;
    endcase
  end

  // A pulse coinciding with ack keeps pending set and leaves overrun as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse   <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      pulse   <= qualified;
      pending <= (pending & ~ack) | pulse;
      overrun <= (overrun & ~(ack & ~pulse)) | (pulse & pending & ~ack);
    end
  end

  assign any_pending = |pending;

  // Descending scan: the last match written is the lowest pending index.
  always_comb begin
    first_idx = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (pending[i-1]) first_idx = IDX_W'(i - 1);
    end
  end

endmodule
